// File: rtl/dock_pkg.sv
// dock_pkg: shared FSM state type, config address map and slot-index width for the dock I/O slot logic
package dock_pkg;
    localparam int SLOT_W = 3;
    localparam logic [7:0] CFG_MINWAIT_BASE = 8'h10;
    localparam logic [7:0] CFG_TIMEOUT = 8'h18;
    typedef enum logic [2:0] {IDLE, MINWAIT, WAITDEV, DONE, TMO} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: W-bit two-flop synchroniser, async active-high reset to all ones
//   clk, rst : clock and async reset
//   i_d      : asynchronous input bits
//   o_q      : synchronised output bits
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    assign o_q = r_sync;
endmodule

// File: rtl/slot_ready_gen.sv
// slot_ready_gen: per-slot ready generation with min wait states, card /WAIT sync and a global timeout
//   clk, rst        : system clock, async active-high reset
//   i_cs_n          : active-low chip selects from the decoder
//   i_slot_wait_n   : asynchronous card wait lines (0 = wait)
//   i_cfg_we/addr/wdata : config register write port
//   i_err_clr       : clears the sticky timeout error
//   o_dev_ready_n   : per-slot ready back to the decoder (0 = stretch)
//   o_err_valid/o_err_slot : sticky timeout error and offending slot
//   o_busy          : FSM not idle
module slot_ready_gen
    import dock_pkg::*;
#(
    parameter int NUM_SLOTS        = 5,
    parameter int WAIT_W           = 4,
    parameter int TMO_W            = 8,
    parameter int DEFAULT_MIN_WAIT = 0,
    parameter int DEFAULT_TIMEOUT  = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SLOTS-1:0] i_cs_n,
    input  logic [NUM_SLOTS-1:0] i_slot_wait_n,
    input  logic                 i_cfg_we,
    input  logic [7:0]           i_cfg_addr,
    input  logic [7:0]           i_cfg_wdata,
    input  logic                 i_err_clr,
    output logic [NUM_SLOTS-1:0] o_dev_ready_n,
    output logic                 o_err_valid,
    output logic [SLOT_W-1:0]    o_err_slot,
    output logic                 o_busy
);
    state_t               r_state, w_next;
    logic [WAIT_W-1:0]    r_min_wait [NUM_SLOTS];
    logic [TMO_W-1:0]     r_timeout;
    logic [SLOT_W-1:0]    r_act_slot;
    logic [WAIT_W-1:0]    r_wcnt;
    logic [TMO_W-1:0]     r_tcnt;
    logic                 r_tmo_en;
    logic                 r_grant;
    logic                 r_err_valid;
    logic [SLOT_W-1:0]    r_err_slot;
    logic [NUM_SLOTS-1:0] w_wsync;
    logic [NUM_SLOTS-1:0] w_grant_vec;
    logic [SLOT_W-1:0]    w_sel_idx;
    logic                 w_sel_any;
    logic                 w_release;
    logic                 w_tmo_hit;
    logic                 w_tmo_enter;

    sync_2ff #(.W(NUM_SLOTS)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (i_slot_wait_n),
        .o_q (w_wsync)
    );

    // lowest active index wins if the decoder ever presents multi-hot selects
    always_comb begin
        w_sel_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (!i_cs_n[i]) w_sel_idx = SLOT_W'(i);
    end
    assign w_sel_any = ~&i_cs_n;

    // tcnt saturates at 0, so a min wait longer than the timeout still times out on WAITDEV entry
    assign w_release = (r_state != IDLE) && i_cs_n[r_act_slot];
    assign w_tmo_hit = r_tmo_en && (r_tcnt <= TMO_W'(1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_sel_any) w_next = (r_min_wait[w_sel_idx] != '0) ? MINWAIT : WAITDEV;
            MINWAIT: if (r_wcnt == WAIT_W'(1)) w_next = WAITDEV;
            WAITDEV: w_next = w_wsync[r_act_slot] ? DONE : w_tmo_hit ? TMO : WAITDEV;
            default: w_next = r_state;
        endcase
        if (w_release) w_next = IDLE;
    end
    assign w_tmo_enter = (r_state == WAITDEV) && (w_next == TMO);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state    <= IDLE;
            r_act_slot <= '0;
            r_wcnt     <= '0;
            r_tcnt     <= '0;
            r_tmo_en   <= 1'b0;
            r_grant    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_grant <= (w_next == DONE) || (w_next == TMO);
            if (r_state == IDLE && w_sel_any) begin
                r_act_slot <= w_sel_idx;
                r_wcnt     <= r_min_wait[w_sel_idx];
                r_tcnt     <= r_timeout;
                r_tmo_en   <= r_timeout != '0;
            end else begin
                if (r_state == MINWAIT) r_wcnt <= r_wcnt - WAIT_W'(1);
                if ((r_state == MINWAIT || r_state == WAITDEV) && r_tcnt != '0) r_tcnt <= r_tcnt - TMO_W'(1);
            end
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) r_min_wait[i] <= WAIT_W'(DEFAULT_MIN_WAIT);
            r_timeout <= TMO_W'(DEFAULT_TIMEOUT);
        end else if (i_cfg_we) begin
            for (int i = 0; i < NUM_SLOTS; i++)
                if (i_cfg_addr == 8'(CFG_MINWAIT_BASE + i)) r_min_wait[i] <= i_cfg_wdata[WAIT_W-1:0];
            if (i_cfg_addr == CFG_TIMEOUT) r_timeout <= i_cfg_wdata[TMO_W-1:0];
        end

    // a new timeout beats a simultaneous clear; otherwise the first logged slot is kept
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_err_valid <= 1'b0;
            r_err_slot  <= '0;
        end else if (w_tmo_enter && (!r_err_valid || i_err_clr)) begin
            r_err_valid <= 1'b1;
            r_err_slot  <= r_act_slot;
        end else if (i_err_clr) begin
            r_err_valid <= 1'b0;
            r_err_slot  <= '0;
        end

    always_comb
        for (int i = 0; i < NUM_SLOTS; i++)
            w_grant_vec[i] = r_grant && (r_act_slot == SLOT_W'(i));

    // reset forces all-ready even while a select is still low
    assign o_dev_ready_n = i_cs_n | w_grant_vec | {NUM_SLOTS{rst}};
    assign o_err_valid   = r_err_valid;
    assign o_err_slot    = r_err_slot;
    assign o_busy        = r_state != IDLE;
endmodule

// File: tb/tb_slot_ready_gen.sv
// tb_slot_ready_gen: directed table plus hand-written sequences for slot_ready_gen
module tb_slot_ready_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] cs_n = 5'b11111;
    logic [4:0] slot_wait_n = 5'b11111;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_addr = 8'h00;
    logic [7:0] cfg_wdata = 8'h00;
    logic       err_clr = 1'b0;
    logic [4:0] dev_ready_n;
    logic       err_valid;
    logic [2:0] err_slot;
    logic       busy;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [4:0] cs_n;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [4:0] exp_rdy;
        logic       exp_busy;
    } vec_t;
    vec_t tbl [26];

    slot_ready_gen dut (
        .clk           (clk),
        .rst           (rst),
        .i_cs_n        (cs_n),
        .i_slot_wait_n (slot_wait_n),
        .i_cfg_we      (cfg_we),
        .i_cfg_addr    (cfg_addr),
        .i_cfg_wdata   (cfg_wdata),
        .i_err_clr     (err_clr),
        .o_dev_ready_n (dev_ready_n),
        .o_err_valid   (err_valid),
        .o_err_slot    (err_slot),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic set_wait(input logic [4:0] v);
        slot_wait_n = v;
        tick();
        tick();
    endtask

    function automatic vec_t mk(input logic [4:0] c, input logic w, input logic [7:0] a,
                                input logic [7:0] d, input logic [4:0] r, input logic b);
        mk = '{cs_n: c, we: w, addr: a, wdata: d, exp_rdy: r, exp_busy: b};
    endfunction

    initial begin
        tbl[0]  = mk(5'b11111, 0, 8'h00, 8'h00, 5'b11111, 0);
        tbl[1]  = mk(5'b11101, 0, 8'h00, 8'h00, 5'b11101, 0);
        tbl[2]  = mk(5'b11101, 0, 8'h00, 8'h00, 5'b11101, 1);
        tbl[3]  = mk(5'b11101, 0, 8'h00, 8'h00, 5'b11111, 1);
        tbl[4]  = mk(5'b11111, 0, 8'h00, 8'h00, 5'b11111, 1);
        tbl[5]  = mk(5'b11111, 0, 8'h00, 8'h00, 5'b11111, 0);
        tbl[6]  = mk(5'b11111, 1, 8'h12, 8'h03, 5'b11111, 0);
        tbl[7]  = mk(5'b11011, 0, 8'h00, 8'h00, 5'b11011, 0);
        tbl[8]  = mk(5'b11011, 0, 8'h00, 8'h00, 5'b11011, 1);
        tbl[9]  = mk(5'b11011, 0, 8'h00, 8'h00, 5'b11011, 1);
        tbl[10] = mk(5'b11011, 0, 8'h00, 8'h00, 5'b11011, 1);
        tbl[11] = mk(5'b11011, 0, 8'h00, 8'h00, 5'b11011, 1);
        tbl[12] = mk(5'b11011, 0, 8'h00, 8'h00, 5'b11111, 1);
        tbl[13] = mk(5'b11111, 0, 8'h00, 8'h00, 5'b11111, 1);
        tbl[14] = mk(5'b11111, 0, 8'h00, 8'h00, 5'b11111, 0);
        tbl[15] = mk(5'b11111, 1, 8'h15, 8'h05, 5'b11111, 0);
        tbl[16] = mk(5'b01111, 0, 8'h00, 8'h00, 5'b01111, 0);
        tbl[17] = mk(5'b01111, 0, 8'h00, 8'h00, 5'b01111, 1);
        tbl[18] = mk(5'b01111, 0, 8'h00, 8'h00, 5'b11111, 1);
        tbl[19] = mk(5'b11111, 0, 8'h00, 8'h00, 5'b11111, 1);
        tbl[20] = mk(5'b11111, 0, 8'h00, 8'h00, 5'b11111, 0);
        tbl[21] = mk(5'b11001, 0, 8'h00, 8'h00, 5'b11001, 0);
        tbl[22] = mk(5'b11001, 0, 8'h00, 8'h00, 5'b11001, 1);
        tbl[23] = mk(5'b11001, 0, 8'h00, 8'h00, 5'b11011, 1);
        tbl[24] = mk(5'b11111, 0, 8'h00, 8'h00, 5'b11111, 1);
        tbl[25] = mk(5'b11111, 0, 8'h00, 8'h00, 5'b11111, 0);

        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset rdy", dev_ready_n, 5'b11111);
        chk("reset busy", busy, 0);
        chk("reset err_valid", err_valid, 0);
        chk("reset err_slot", err_slot, 0);

        for (int i = 0; i < 26; i++) begin
            cs_n = tbl[i].cs_n;
            cfg_we = tbl[i].we;
            cfg_addr = tbl[i].addr;
            cfg_wdata = tbl[i].wdata;
            #1;
            chk($sformatf("vec%0d rdy", i), dev_ready_n, tbl[i].exp_rdy);
            chk($sformatf("vec%0d busy", i), busy, tbl[i].exp_busy);
            tick();
        end
        cfg_we = 1'b0;
        chk("table err_valid", err_valid, 0);

        set_wait(5'b10111);
        cs_n = 5'b10111;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("cardwait c%0d rdy", k), dev_ready_n[3], 0);
            chk($sformatf("cardwait c%0d busy", k), busy, 1);
        end
        slot_wait_n = 5'b11111;
        #1;
        chk("cardwait rel0", dev_ready_n[3], 0);
        tick();
        chk("cardwait rel1", dev_ready_n[3], 0);
        tick();
        chk("cardwait rel2", dev_ready_n[3], 0);
        tick();
        chk("cardwait rel3", dev_ready_n[3], 1);
        chk("cardwait err_valid", err_valid, 0);
        cs_n = 5'b11111;
        tick();
        chk("cardwait idle", busy, 0);

        cfg_write(8'h18, 8'd10);
        set_wait(5'b01110);
        cs_n = 5'b01111;
        tick();
        chk("tmo4 e0 rdy", dev_ready_n[4], 0);
        for (int k = 1; k < 10; k++) begin
            tick();
            chk($sformatf("tmo4 e%0d rdy", k), dev_ready_n[4], 0);
        end
        chk("tmo4 e9 err_valid", err_valid, 0);
        tick();
        chk("tmo4 e10 rdy", dev_ready_n[4], 1);
        chk("tmo4 err_valid", err_valid, 1);
        chk("tmo4 err_slot", err_slot, 4);
        chk("tmo4 busy", busy, 1);
        cs_n = 5'b11111;
        tick();
        chk("tmo4 idle", busy, 0);

        cs_n = 5'b11110;
        repeat (11) tick();
        chk("tmo0 rdy", dev_ready_n[0], 1);
        chk("tmo0 err_valid", err_valid, 1);
        chk("tmo0 keeps slot", err_slot, 4);
        cs_n = 5'b11111;
        tick();

        cs_n = 5'b11110;
        repeat (10) tick();
        chk("clrtmo pre rdy", dev_ready_n[0], 0);
        chk("clrtmo pre slot", err_slot, 4);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clrtmo err_valid", err_valid, 1);
        chk("clrtmo err_slot", err_slot, 0);
        cs_n = 5'b11111;
        tick();

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr err_valid", err_valid, 0);
        chk("clr err_slot", err_slot, 0);

        set_wait(5'b11111);
        cs_n = 5'b11011;
        tick();
        tick();
        chk("abort busy", busy, 1);
        chk("abort rdy", dev_ready_n, 5'b11011);
        cs_n = 5'b11111;
        tick();
        chk("abort idle", busy, 0);
        chk("abort err_valid", err_valid, 0);

        cfg_write(8'h18, 8'd3);
        set_wait(5'b10111);
        cs_n = 5'b10111;
        tick();
        tick();
        tick();
        chk("tmo3 e2 rdy", dev_ready_n[3], 0);
        tick();
        chk("tmo3 e3 rdy", dev_ready_n[3], 1);
        chk("tmo3 err_valid", err_valid, 1);
        chk("tmo3 err_slot", err_slot, 3);
        cs_n = 5'b11111;
        tick();

        cs_n = 5'b10111;
        tick();
        tick();
        chk("midrst busy pre", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst rdy", dev_ready_n, 5'b11111);
        chk("midrst err_valid", err_valid, 0);
        chk("midrst err_slot", err_slot, 0);
        tick();
        cs_n = 5'b11111;
        rst = 1'b0;
        tick();
        chk("post rst busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/slot_ready_gen.md
Name: slot_ready_gen

Overview:
Downstream companion of the Dock I/O address decoder. It consumes the decoder's one-hot active-low chip selects and produces the per-slot `dev_ready_n` vector that the decoder uses to stretch `ready_n`. Per-slot programmable minimum wait states are inserted, and each card's asynchronous `/WAIT` line is synchronised. A global timeout force-completes a hung cycle and latches the offending slot as a sticky bus error.

Parameters:
NUM_SLOTS, 5, number of card slots (width of `cs_n` / `dev_ready_n`)
WAIT_W, 4, width of each per-slot minimum-wait register
TMO_W, 8, width of the global timeout counter
DEFAULT_MIN_WAIT, 0, reset value of every min-wait register
DEFAULT_TIMEOUT, 255, reset value of the timeout register (0 = timeout disabled)

Ports:
clk  in  1  single system clock, the same clock as the decoder; all logic rises on this edge
rst  in  1  asynchronous, active-high reset
cs_n  in  NUM_SLOTS  chip selects from the decoder; active low, one-hot when any is active
slot_wait_n  in  NUM_SLOTS  raw card wait lines; asynchronous; 0 = card requests wait
cfg_we  in  1  config write strobe, synchronous to clk
cfg_addr  in  8  config register address
cfg_wdata  in  8  config write data
err_clr  in  1  one-cycle pulse that clears the sticky error
dev_ready_n  out  NUM_SLOTS  to decoder; 1 = slot ready/complete, 0 = stretch
err_valid  out  1  sticky timeout error flag
err_slot  out  3  slot index of the first unacknowledged timeout
busy  out  1  high while the FSM is not in IDLE

Behaviour:
Reset:
- `rst` high asynchronously forces the FSM to IDLE, clears the internal grant, and drives `dev_ready_n` all 1s.
- `err_valid`=0, `err_slot`=0, `busy`=0.
- Synchroniser flops reset to 1. Min-wait registers reset to DEFAULT_MIN_WAIT; timeout register resets to DEFAULT_TIMEOUT.
- A reset mid-cycle abandons the cycle silently; no error is logged.

Config map (writes only; unmapped addresses are ignored):
- 0x10+s, s < NUM_SLOTS: min_wait[s] = cfg_wdata[WAIT_W-1:0].
- 0x18: timeout = cfg_wdata[TMO_W-1:0].
- A write during an active cycle takes effect at the next cycle start, because counters are loaded only on the IDLE exit.

Synchronisation:
- `slot_wait_n` passes through a 2-flop synchroniser per bit; `wsync[s]` is the result.

Selection:
- The active slot is the lowest index s with cs_n[s]=0. Multi-hot cs_n is not legal from the decoder but resolves by lowest index.

Output:
- dev_ready_n[s] = cs_n[s] OR (grant AND act_slot==s).
- An unselected slot therefore reads 1. The selected slot reads 0 combinationally from the first cycle cs_n is low, so the decoder never sees a false ready on entry.

FSM states: IDLE, MINWAIT, WAITDEV, DONE, TMO. E0 is the edge at which the FSM first samples cs_n[s]=0.
- IDLE: on any cs_n low:
  - capture act_slot, load wcnt=min_wait[act_slot] and tcnt=timeout;
  - go to MINWAIT if wcnt≠0, else WAITDEV.
- MINWAIT: decrement wcnt each cycle; when wcnt reaches 1, go to WAITDEV.
- WAITDEV:
  - if wsync[act_slot]=1, set grant and go to DONE;
  - else if timeout≠0 and tcnt==1, set grant and go to TMO;
  - tcnt decrements every cycle in MINWAIT and WAITDEV; with timeout=0 the FSM waits indefinitely.
- DONE / TMO: hold grant until cs_n[act_slot]=1, then clear grant and return to IDLE.
- Early release: cs_n[act_slot] returning to 1 in any non-IDLE state returns the FSM to IDLE on that edge, with no error.

Latency:
- With min_wait=N and the card ready, grant is registered at edge E(N+1), so dev_ready_n[s] rises after E(N+1).
- Timeout fires after exactly `timeout` cycles counted from E0 when the card never releases wait.

Error register:
- Entering TMO with err_valid=0 sets err_valid and err_slot=act_slot.
- A further timeout while err_valid=1 keeps the original err_slot.
- err_clr clears err_valid and err_slot.
- If err_clr and a new timeout occur on the same edge, the new timeout wins (set, with the new slot).

busy = (state ≠ IDLE).

Decomposition:
- Shared package `dock_pkg`:
  - FSM state enum (IDLE, MINWAIT, WAITDEV, DONE, TMO);
  - config address constants CFG_MINWAIT_BASE=0x10 and CFG_TIMEOUT=0x18;
  - slot-index width constant.
- Sub-module `sync_2ff`: a parameterised-width 2-flop synchroniser with async active-high reset to all 1s, instantiated once for `slot_wait_n`.

Test Plan:
- Reset, idle defaults: rst high then low → dev_ready_n=5'b11111, busy=0, err_valid=0.
- Zero wait: min_wait=0, slot_wait_n=11111, assert cs_n=5'b11101 → dev_ready_n[1]=0 immediately, =1 after E1; release cs_n → busy=0 one edge later.
- Min wait: write 0x12=3, select slot 2 with card ready → dev_ready_n[2] low through E3, high after E4.
- Card wait: slot 3 with slot_wait_n[3]=0 for 6 cycles then 1 → grant 2 sync cycles after release; err_valid stays 0.
- Timeout: write 0x18=10, slot 4 with slot_wait_n[4] held 0 → dev_ready_n[4] rises after E10, err_valid=1, err_slot=4.
  - A second timeout on slot 0 leaves err_slot=4.
  - err_clr on the same edge as a new slot-0 timeout → err_valid=1, err_slot=0.
- Abort and mid-reset: drop cs_n mid-MINWAIT → IDLE, no error. Assert rst during WAITDEV → all outputs return to their reset values immediately (asynchronously).
